// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/EXEC/HALT sequencer with PC update.
// Fetches over a req/ack memory port and selects the next PC in EXEC.
module fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  output logic [PC_W-1:0]    ImemAddr,
  output logic               ImemReq,
  input  logic               ImemAck,
  input  logic [INSTR_W-1:0] ImemData,
  input  logic               PCInc_Op,
  input  logic               Beq_Op,
  input  logic [1:0]         JiJr_Op,
  input  logic               Zero,
  input  logic [PC_W-1:0]    RegJmpAddr,
  input  logic               Stall,
  output logic [INSTR_W-1:0] Instr,
  output logic [3:0]         Oper,
  output logic               InstrValid,
  output logic [PC_W-1:0]    PC
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] w_instr_nxt;
  logic [PC_W-1:0]    w_off;
  logic [PC_W-1:0]    w_pc_inc;
  logic [PC_W-1:0]    w_pc_br;

  // Branch offset is Instr[7:0], sign-extended or truncated to PC width
  if (PC_W > 8) begin : g_sx
    assign w_off = {{(PC_W-8){r_instr[7]}}, r_instr[7:0]};
  end else begin : g_tr
    assign w_off = r_instr[PC_W-1:0];
  end

  assign w_pc_inc = r_pc + PC_ONE;
  assign w_pc_br  = w_pc_inc + w_off;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (ImemAck) begin
          w_instr_nxt = ImemData;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!Stall) begin
          w_state_nxt = S_FETCH;
          if (JiJr_Op == 2'b01) begin
            w_pc_nxt = r_instr[PC_W-1:0];
          end else if (JiJr_Op == 2'b10) begin
            w_pc_nxt = RegJmpAddr;
          end else if (Beq_Op && Zero) begin
            w_pc_nxt = w_pc_br;
          end else if (Beq_Op || PCInc_Op) begin
            w_pc_nxt = w_pc_inc;
          end else begin
            w_state_nxt = S_HALT;
          end
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  // Handshake outputs come from registered state only
  assign ImemReq    = (r_state == S_FETCH);
  assign InstrValid = (r_state == S_EXEC);
  assign ImemAddr   = r_pc;
  assign PC         = r_pc;
  assign Instr      = r_instr;
  assign Oper       = r_instr[INSTR_W-1:INSTR_W-4];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus
// randomized instruction stream against a next-PC reference model.
module tb_fetch_unit;

  logic        Clk;
  logic        Reset_n;
  logic [7:0]  ImemAddr;
  logic        ImemReq;
  logic        ImemAck;
  logic [15:0] ImemData;
  logic        PCInc_Op;
  logic        Beq_Op;
  logic [1:0]  JiJr_Op;
  logic        Zero;
  logic [7:0]  RegJmpAddr;
  logic        Stall;
  logic [15:0] Instr;
  logic [3:0]  Oper;
  logic        InstrValid;
  logic [7:0]  PC;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_pc = 0;
  bit exp_halt = 0;

  fetch_unit #(.PC_W(8), .INSTR_W(16)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .ImemAddr(ImemAddr),
    .ImemReq(ImemReq),
    .ImemAck(ImemAck),
    .ImemData(ImemData),
    .PCInc_Op(PCInc_Op),
    .Beq_Op(Beq_Op),
    .JiJr_Op(JiJr_Op),
    .Zero(Zero),
    .RegJmpAddr(RegJmpAddr),
    .Stall(Stall),
    .Instr(Instr),
    .Oper(Oper),
    .InstrValid(InstrValid),
    .PC(PC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next PC from the architectural rules, using plain integer arithmetic
  function automatic int model_next(input int pc, input int ins,
                                    input bit inc, input bit beq,
                                    input bit zero, input int jj,
                                    input int rj, output bit halt);
    int off;
    halt = 0;
    off = ins % 256;
    if (off >= 128) off = off - 256;
    if (jj == 1) return ins % 256;
    if (jj == 2) return rj;
    if (beq && zero) return (pc + 1 + off + 256) % 256;
    if (beq || inc) return (pc + 1) % 256;
    halt = 1;
    return pc;
  endfunction

  task automatic clr_ctrl();
    PCInc_Op   = 1'b0;
    Beq_Op     = 1'b0;
    Zero       = 1'b0;
    JiJr_Op    = 2'b00;
    RegJmpAddr = 8'h00;
    Stall      = 1'b0;
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves one cycle after EXEC
  task automatic fetch_exec(input int dly, input logic [15:0] data,
                            input int nstall, input bit inc,
                            input bit beq, input bit zero,
                            input logic [1:0] jj, input logic [7:0] rj);
    int nxt;
    bit h;
    for (int k = 0; k <= dly; k++) begin
      chk("fetch_req", 32'(ImemReq), 1);
      chk("fetch_addr", 32'(ImemAddr), exp_pc);
      chk("fetch_valid", 32'(InstrValid), 0);
      ImemAck  = (k == dly);
      ImemData = (k == dly) ? data : 16'($urandom);
      @(negedge Clk);
    end
    ImemAck = 1'b0;
    chk("exec_valid", 32'(InstrValid), 1);
    chk("exec_req", 32'(ImemReq), 0);
    chk("exec_instr", 32'(Instr), 32'(data));
    chk("exec_oper", 32'(Oper), 32'(data[15:12]));
    chk("exec_pc", 32'(PC), exp_pc);
    for (int s = 0; s < nstall; s++) begin
      Stall      = 1'b1;
      PCInc_Op   = 1'($urandom);
      Beq_Op     = 1'($urandom);
      Zero       = 1'($urandom);
      JiJr_Op    = 2'($urandom);
      RegJmpAddr = 8'($urandom);
      ImemAck    = 1'($urandom);
      ImemData   = 16'($urandom);
      @(negedge Clk);
      chk("stall_valid", 32'(InstrValid), 1);
      chk("stall_req", 32'(ImemReq), 0);
      chk("stall_pc", 32'(PC), exp_pc);
      chk("stall_instr", 32'(Instr), 32'(data));
    end
    Stall      = 1'b0;
    PCInc_Op   = inc;
    Beq_Op     = beq;
    Zero       = zero;
    JiJr_Op    = jj;
    RegJmpAddr = rj;
    ImemAck    = 1'($urandom);
    ImemData   = 16'($urandom);
    nxt = model_next(exp_pc, int'(data), inc, beq, zero, int'(jj),
                     int'(rj), h);
    @(negedge Clk);
    ImemAck = 1'b0;
    clr_ctrl();
    exp_pc   = nxt;
    exp_halt = h;
    if (h) begin
      chk("halt_req", 32'(ImemReq), 0);
      chk("halt_valid", 32'(InstrValid), 0);
      chk("halt_pc", 32'(PC), exp_pc);
    end
  endtask

  initial begin
    bit         r_inc;
    bit         r_beq;
    logic [1:0] r_jj;
    Reset_n  = 1'b0;
    ImemAck  = 1'b1;
    ImemData = 16'h1234;
    clr_ctrl();
    repeat (2) @(negedge Clk);
    chk("rst_req", 32'(ImemReq), 0);
    chk("rst_valid", 32'(InstrValid), 0);
    chk("rst_pc", 32'(PC), 0);
    chk("rst_addr", 32'(ImemAddr), 0);
    chk("rst_instr", 32'(Instr), 0);
    chk("rst_oper", 32'(Oper), 0);

    // Ack while in IDLE must not load Instr
    ImemData = 16'hBEEF;
    Reset_n  = 1'b1;
    @(negedge Clk);
    chk("idle_ack_instr", 32'(Instr), 0);
    chk("first_req", 32'(ImemReq), 1);
    chk("first_addr", 32'(ImemAddr), 0);
    ImemAck = 1'b0;

    for (int i = 0; i < 4; i++)
      fetch_exec(0, 16'h1000, 0, 1, 0, 0, 2'b00, 8'h00);
    chk("seq_pc4", 32'(PC), 4);
    fetch_exec(3, 16'h1000, 0, 1, 0, 0, 2'b00, 8'h00);
    chk("wait_pc5", 32'(PC), 5);
    fetch_exec(0, 16'h20FE, 0, 0, 1, 1, 2'b00, 8'h00);
    chk("beq_taken", 32'(PC), 4);
    fetch_exec(0, 16'h1000, 0, 1, 0, 0, 2'b00, 8'h00);
    fetch_exec(0, 16'h20FE, 0, 0, 1, 0, 2'b00, 8'h00);
    chk("beq_not_taken", 32'(PC), 6);
    fetch_exec(0, 16'h3010, 0, 0, 0, 0, 2'b01, 8'h00);
    chk("jimm_10", 32'(PC), 32'h10);
    fetch_exec(0, 16'h402A, 0, 0, 1, 1, 2'b01, 8'h00);
    chk("jump_wins", 32'(PC), 32'h2A);
    fetch_exec(0, 16'h5000, 0, 0, 0, 0, 2'b10, 8'h80);
    chk("jreg", 32'(PC), 32'h80);
    fetch_exec(0, 16'h6000, 0, 1, 0, 0, 2'b11, 8'h33);
    chk("jj11_inc", 32'(PC), 32'h81);
    fetch_exec(0, 16'h70FF, 0, 0, 0, 0, 2'b01, 8'h00);
    fetch_exec(0, 16'h1000, 0, 1, 0, 0, 2'b00, 8'h00);
    chk("wrap", 32'(PC), 0);

    for (int i = 0; i < 40; i++) begin
      r_inc = 1'($urandom);
      r_beq = 1'($urandom);
      r_jj  = 2'($urandom);
      if (!r_inc && !r_beq && r_jj != 2'b01 && r_jj != 2'b10) r_inc = 1'b1;
      fetch_exec(int'($urandom_range(0, 3)), 16'($urandom),
                 int'($urandom_range(0, 2)), r_inc, r_beq,
                 1'($urandom), r_jj, 8'($urandom));
    end

    fetch_exec(0, 16'h8000, 3, 0, 0, 0, 2'b00, 8'h00);
    chk("halt_entered", 32'(exp_halt), 1);
    for (int i = 0; i < 20; i++) begin
      ImemAck  = 1'($urandom);
      ImemData = 16'($urandom);
      PCInc_Op = 1'($urandom);
      @(negedge Clk);
      chk("halt_hold_req", 32'(ImemReq), 0);
      chk("halt_hold_valid", 32'(InstrValid), 0);
      chk("halt_hold_pc", 32'(PC), exp_pc);
    end
    ImemAck = 1'b0;
    clr_ctrl();

    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    exp_pc  = 0;
    @(negedge Clk);
    fetch_exec(0, 16'h1000, 0, 1, 0, 0, 2'b00, 8'h00);
    fetch_exec(0, 16'h1000, 0, 1, 0, 0, 2'b00, 8'h00);
    chk("pre_rst_req", 32'(ImemReq), 1);
    chk("pre_rst_pc", 32'(PC), 2);
    #2 Reset_n = 1'b0;
    #1;
    chk("midrst_req", 32'(ImemReq), 0);
    chk("midrst_pc", 32'(PC), 0);
    chk("midrst_instr", 32'(Instr), 0);
    @(negedge Clk);
    Reset_n  = 1'b1;
    ImemAck  = 1'b1;
    ImemData = 16'hABCD;
    @(negedge Clk);
    chk("restart_instr", 32'(Instr), 0);
    ImemAck = 1'b0;
    exp_pc  = 0;
    fetch_exec(1, 16'h1000, 0, 1, 0, 0, 2'b00, 8'h00);
    chk("restart_pc", 32'(PC), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
